// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port main-RAM arbiter.
// Access sizes, FSM states and the latched request bundle.
package mem_arb_pkg;

   localparam int unsigned MEM_SIZE = 4096;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      MA_IDLE = 2'd0,
      MA_BUSY = 2'd1,
      MA_ACK  = 2'd2
   } ma_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sign;
      logic        we;
      logic [31:0] wdata;
   } ma_req_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] n;
      unique case (size)
         SZ_B:    n = 3'd1;
         SZ_H:    n = 3'd2;
         SZ_W:    n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester ports (fetch = 0, load/store = 1) and the single RAM port.
// slave is the arbiter side, master is the requester/RAM side.
interface mem_arb_if;

   logic        i_req0;
   logic [31:0] i_addr0;
   logic [1:0]  i_size0;
   logic        i_sign0;
   logic        i_we0;
   logic [31:0] i_wdata0;
   logic        o_ack0;
   logic        o_err0;

   logic        i_req1;
   logic [31:0] i_addr1;
   logic [1:0]  i_size1;
   logic        i_sign1;
   logic        i_we1;
   logic [31:0] i_wdata1;
   logic        o_ack1;
   logic        o_err1;

   logic [31:0] o_rdata;

   logic [31:0] o_ram_addr;
   logic [2:0]  o_ram_insize;
   logic        o_ram_insign;
   logic [2:0]  o_ram_outsize;
   logic [31:0] o_ram_data;
   logic [31:0] i_ram_data;

   modport slave (
      input  i_req0, i_addr0, i_size0, i_sign0, i_we0, i_wdata0,
      input  i_req1, i_addr1, i_size1, i_sign1, i_we1, i_wdata1,
      input  i_ram_data,
      output o_ack0, o_err0, o_ack1, o_err1, o_rdata,
      output o_ram_addr, o_ram_insize, o_ram_insign,
      output o_ram_outsize, o_ram_data
   );

   modport master (
      output i_req0, i_addr0, i_size0, i_sign0, i_we0, i_wdata0,
      output i_req1, i_addr1, i_size1, i_sign1, i_we1, i_wdata1,
      output i_ram_data,
      input  o_ack0, o_err0, o_ack1, o_err1, o_rdata,
      input  o_ram_addr, o_ram_insize, o_ram_insign,
      input  o_ram_outsize, o_ram_data
   );

endinterface

// File: rtl/mem_arb_chk.sv
// Access legality: size code, natural alignment and RAM bounds.
// End address is formed in 33 bits so 0xFFFFFFFC + 4 cannot wrap.
module mem_arb_chk
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_SIZE
) (
   input  logic [31:0] addr_i,
   input  logic [1:0]  size_i,
   output logic [2:0]  nbytes_o,
   output logic        illegal_o
);

   logic [32:0] end_w;
   logic        mis;

   always_comb begin
      nbytes_o = size_bytes(size_i);
      end_w    = {1'b0, addr_i} + {30'd0, nbytes_o};
      mis      = 1'b0;
      unique case (size_i)
         SZ_H:    mis = addr_i[0];
         SZ_W:    mis = |addr_i[1:0];
         default: mis = 1'b0;
      endcase
      illegal_o = (size_i == 2'd3) | mis
                | (end_w > 33'(MEM_BYTES));
   end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter/sequencer in front of the byte-addressed main RAM.
// Grant -> one RAM cycle -> ack/err pulse with registered read data.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_SIZE,
   parameter bit          RR_INIT   = 1'b1
) (
   input  logic      i_clk,
   input  logic      i_rst,
   mem_arb_if.slave  bus
);

   ma_state_e   state_q, state_d;
   logic        rr_q, rr_d;
   logic        win_q, win_d;
   ma_req_t     req_q, req_d;
   logic [31:0] rdata_q, rdata_d;

   logic [1:0]  req;
   ma_req_t     in0, in1;
   logic [2:0]  nbytes;
   logic        illegal;
   logic        gnt_v;
   logic        gnt_p;

   assign req = {bus.i_req1, bus.i_req0};
   assign in0 = {bus.i_addr0, bus.i_size0, bus.i_sign0,
                 bus.i_we0, bus.i_wdata0};
   assign in1 = {bus.i_addr1, bus.i_size1, bus.i_sign1,
                 bus.i_we1, bus.i_wdata1};

   mem_arb_chk #(
      .MEM_BYTES (MEM_BYTES)
   ) u_chk (
      .addr_i    (req_q.addr),
      .size_i    (req_q.size),
      .nbytes_o  (nbytes),
      .illegal_o (illegal)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= MA_IDLE;
         rr_q    <= RR_INIT;
         win_q   <= 1'b0;
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      win_d   = win_q;
      req_d   = req_q;
      rdata_d = '0;
      gnt_v   = 1'b0;
      gnt_p   = 1'b0;
      unique case (state_q)
         MA_IDLE: begin
            if (|req) begin
               gnt_v = 1'b1;
               gnt_p = (&req) ? rr_q : req[1];
            end
         end
         MA_BUSY: begin
            state_d = MA_ACK;
            if (!illegal && !req_q.we)
               rdata_d = bus.i_ram_data;
         end
         MA_ACK: begin
            state_d = MA_IDLE;
            // winner's request is still high here; only the other port may win
            if (req[~win_q]) begin
               gnt_v = 1'b1;
               gnt_p = ~win_q;
            end
         end
         default: state_d = MA_IDLE;
      endcase
      if (gnt_v) begin
         state_d = MA_BUSY;
         win_d   = gnt_p;
         rr_d    = ~gnt_p;
         req_d   = gnt_p ? in1 : in0;
      end
   end

   always_comb begin
      bus.o_ram_addr    = '0;
      bus.o_ram_insize  = '0;
      bus.o_ram_insign  = 1'b0;
      bus.o_ram_outsize = '0;
      bus.o_ram_data    = '0;
      if (state_q == MA_BUSY && !i_rst) begin
         bus.o_ram_addr = req_q.addr;
         if (!illegal) begin
            if (req_q.we) begin
               bus.o_ram_outsize = nbytes;
               bus.o_ram_data    = req_q.wdata;
            end else begin
               bus.o_ram_insize = nbytes;
               bus.o_ram_insign = req_q.sign;
            end
         end
      end
   end

   always_comb begin
      bus.o_ack0  = (state_q == MA_ACK) && !win_q && !i_rst;
      bus.o_ack1  = (state_q == MA_ACK) && win_q && !i_rst;
      bus.o_err0  = bus.o_ack0 && illegal;
      bus.o_err1  = bus.o_ack1 && illegal;
      bus.o_rdata = i_rst ? 32'd0 : rdata_q;
   end

endmodule
